// File: rtl/psram_wbuf.sv
// Write-posting buffer in front of psram_top: posts writes into a small FIFO, drains them in order,
// and holds reads behind pending writes. Define PSRAM_WBUF_FWD_EN for read-after-write forwarding.
module psram_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 24
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       s_valid_i,
    input  logic [31:0]                s_addr_i,
    input  logic [31:0]                s_wdata_i,
    input  logic [3:0]                 s_wstrb_i,
    output logic [31:0]                s_rdata_o,
    output logic                       s_ready_o,
    output logic                       m_valid_o,
    output logic [31:0]                m_addr_o,
    output logic [31:0]                m_wdata_o,
    output logic [3:0]                 m_wstrb_o,
    input  logic [31:0]                m_rdata_i,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_cnt_o,
    output logic                       busy_o
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_WR_ACK, ST_RD_WAIT, ST_RD_REQ, ST_RD_ACK} state_t;

    state_t          r_state;
    logic            r_s_ready;
    logic [31:0]     r_rdata;
    logic [AW-1:0]   r_rd_addr;
    logic [AW-1:0]   r_fa [DEPTH];
    logic [31:0]     r_fd [DEPTH];
    logic [3:0]      r_fs [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW:0]     r_cnt;
    logic            r_dr_vld;

    logic            w_full;
    logic            w_empty;
    logic            w_is_wr;
    logic            w_push;
    logic            w_pop;
    logic            w_dr_start;
    logic            w_rd_req;
    logic            w_fwd_use;
    logic [31:0]     w_fwd_data;
    logic            w_unused;

    assign w_full     = (r_cnt == (PW+1)'(DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign w_is_wr    = (s_wstrb_i != 4'h0);
    assign w_rd_req   = (r_state == ST_RD_REQ);
    assign w_push     = (r_state == ST_IDLE) && s_valid_i && w_is_wr && !w_full;
    assign w_pop      = r_dr_vld && m_ready_i;
    // A fresh entry is only launched from a cycle where m_valid_o was low, giving the mandatory gap.
    assign w_dr_start = !r_dr_vld && !w_empty && !w_rd_req;
    assign w_unused   = ^(s_addr_i >> AW);

`ifdef PSRAM_WBUF_FWD_EN
    logic w_fwd_hit;
    logic w_fwd_full;

    // Later (newer) matching entries overwrite earlier ones, so the newest match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_full = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((PW+1)'(k) < r_cnt) &&
                (r_fa[r_rptr + PW'(k)][AW-1:2] == s_addr_i[AW-1:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_full = (r_fs[r_rptr + PW'(k)] == 4'hF);
                w_fwd_data = r_fd[r_rptr + PW'(k)];
            end
        end
    end

    assign w_fwd_use = w_fwd_hit && w_fwd_full;
`else
    assign w_fwd_use  = 1'b0;
    assign w_fwd_data = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_s_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_valid_i) begin
                        if (w_is_wr) begin
                            if (!w_full) begin
                                r_state   <= ST_WR_ACK;
                                r_s_ready <= 1'b1;
                            end
                        end else if (w_fwd_use) begin
                            r_rdata   <= w_fwd_data;
                            r_state   <= ST_RD_ACK;
                            r_s_ready <= 1'b1;
                        end else begin
                            r_state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_WR_ACK: r_state <= ST_IDLE;
                ST_RD_WAIT: begin
                    if (w_empty && !r_dr_vld) r_state <= ST_RD_REQ;
                end
                ST_RD_REQ: begin
                    if (m_ready_i) begin
                        r_rdata   <= m_rdata_i;
                        r_state   <= ST_RD_ACK;
                        r_s_ready <= 1'b1;
                    end
                end
                ST_RD_ACK: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if ((r_state == ST_IDLE) && s_valid_i && !w_is_wr) r_rd_addr <= s_addr_i[AW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_dr_vld <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
            if (w_pop)           r_dr_vld <= 1'b0;
            else if (w_dr_start) r_dr_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fa[r_wptr] <= s_addr_i[AW-1:0];
            r_fd[r_wptr] <= s_wdata_i;
            r_fs[r_wptr] <= s_wstrb_i;
        end
    end

    // Drain and read never overlap, so a simple priority mux is enough; idle bus shows zeros.
    assign m_valid_o  = r_dr_vld || w_rd_req;
    assign m_addr_o   = r_dr_vld ? 32'(r_fa[r_rptr]) : (w_rd_req ? 32'(r_rd_addr) : 32'h0);
    assign m_wdata_o  = r_dr_vld ? r_fd[r_rptr] : 32'h0;
    assign m_wstrb_o  = r_dr_vld ? r_fs[r_rptr] : 4'h0;
    assign s_ready_o  = r_s_ready;
    assign s_rdata_o  = r_rdata;
    assign fifo_cnt_o = r_cnt;
    assign busy_o     = !w_empty || r_dr_vld || w_rd_req;

endmodule

// File: tb/tb_psram_wbuf.sv
// Self-checking bench for psram_wbuf: directed scenarios plus randomized traffic against
// a word-level memory model and an in-order expected-drain queue.
module tb_psram_wbuf;
    localparam int DEPTH = 4;
    localparam int AW    = 24;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] AMASK = 32'h00FF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid_i;
    logic [31:0]   s_addr_i, s_wdata_i;
    logic [3:0]    s_wstrb_i;
    logic [31:0]   s_rdata_o;
    logic          s_ready_o;
    logic          m_valid_o;
    logic [31:0]   m_addr_o, m_wdata_o;
    logic [3:0]    m_wstrb_o;
    logic [31:0]   m_rdata_i;
    logic          m_ready_i;
    logic [CW-1:0] fifo_cnt_o;
    logic          busy_o;

    psram_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_valid_i(s_valid_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
        .s_rdata_o(s_rdata_o), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
        .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i),
        .fifo_cnt_o(fifo_cnt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] sl_mem  [int];
    bit          sl_hold = 1'b0;
    bit          sl_rand = 1'b0;
    int          sl_lat  = 1;
    int          sl_cnt  = 0;
    int          n_drains = 0;
    int          n_rd_down = 0;
    bit          rd_force = 1'b0;
    logic [31:0] rd_force_val = '0;
    logic [31:0] exp_rd_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input int w);
        return 32'h5A00_0000 ^ 32'(w);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] sl_rd(input int w);
        return sl_mem.exists(w) ? sl_mem[w] : dflt(w);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a & AMASK) >> 2);
    endfunction

    // Downstream PSRAM stand-in: completes each request sl_lat cycles after it appears.
    initial begin
        wr_t e;
        int  w;
        m_ready_i = 1'b0;
        m_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || m_ready_i) begin
                m_ready_i = 1'b0;
                sl_cnt = 0;
            end else if (m_valid_o && !sl_hold) begin
                sl_cnt++;
                if (sl_cnt >= sl_lat) begin
                    w = word_of(m_addr_o);
                    if (m_wstrb_o != 4'h0) begin
                        n_drains++;
                        check("drain_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("drain_addr", m_addr_o, e.a);
                            check("drain_data", m_wdata_o, e.d);
                            check("drain_strb", 32'(m_wstrb_o), 32'(e.s));
                        end
                        sl_mem[w] = merge(sl_rd(w), m_wdata_o, m_wstrb_o);
                    end else begin
                        n_rd_down++;
                        check("rd_addr", m_addr_o, exp_rd_addr);
                        m_rdata_i = rd_force ? rd_force_val : sl_rd(w);
                        rd_force = 1'b0;
                    end
                    m_ready_i = 1'b1;
                    sl_cnt = 0;
                    if (sl_rand) sl_lat = $urandom_range(1, 4);
                end
            end else begin
                sl_cnt = 0;
            end
        end
    end

    // Issues one upstream request; lat is the number of clock edges up to the completing one.
    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                       output logic [31:0] rd, output int lat);
        bit ok;
        wr_t e;
        @(posedge clk); #1;
        s_valid_i = 1'b1; s_addr_i = a; s_wdata_i = d; s_wstrb_i = st;
        if (st == 4'h0) exp_rd_addr = a & AMASK;
        ok = 1'b0;
        lat = 0;
        while (!ok && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (s_ready_o) ok = 1'b1;
        end
        lat = lat + 1;
        rd = s_rdata_o;
        s_valid_i = 1'b0;
        check("req_ack", 32'(ok), 32'd1);
        if (ok && st != 4'h0) begin
            e.a = a & AMASK; e.d = d; e.s = st;
            exp_q.push_back(e);
            ref_mem[word_of(a)] = merge(ref_rd(word_of(a)), d, st);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy_o || m_ready_i) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, sv, a, d;
        logic [3:0]  st;
        int          lat, d0, r0, n, w, rsel;
        bit          ok;
        wr_t         e;

        rst_n = 1'b0;
        s_valid_i = 1'b0; s_addr_i = '0; s_wdata_i = '0; s_wstrb_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid_o), 32'd0);
        check("rst_s_ready", 32'(s_ready_o), 32'd0);
        check("rst_cnt", 32'(fifo_cnt_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rdata", s_rdata_o, 32'd0);
        check("rst_m_addr", m_addr_o, 32'd0);
        rst_n = 1'b1;

        // Single write, downstream answers 3 cycles after m_valid_o
        sl_lat = 3;
        req(32'h0000_0010, 32'hA5A5_1234, 4'hF, rd, lat);
        check("wr1_lat", 32'(lat), 32'd2);
        n = 0;
        while (!m_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        check("wr1_m_valid", 32'(m_valid_o), 32'd1);
        check("wr1_m_addr", m_addr_o, 32'h0000_0010);
        check("wr1_m_wdata", m_wdata_o, 32'hA5A5_1234);
        check("wr1_m_wstrb", 32'(m_wstrb_o), 32'hF);
        check("wr1_cnt_busy", 32'(fifo_cnt_o), 32'd1);
        wait_idle("wr1_idle");
        check("wr1_cnt_done", 32'(fifo_cnt_o), 32'd0);

        // Fill the FIFO with the downstream stalled, then a fifth write must wait
        sl_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req(32'h50 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, rd, lat);
            check("fill_lat", 32'(lat), 32'd2);
        end
        @(posedge clk); #1;
        s_valid_i = 1'b1; s_addr_i = 32'h60; s_wdata_i = 32'hB000_0004; s_wstrb_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("wr5_stall_rdy", 32'(s_ready_o), 32'd0);
        end
        check("wr5_full_cnt", 32'(fifo_cnt_o), DEPTH);
        check("wr5_m_valid", 32'(m_valid_o), 32'd1);
        d0 = n_drains;
        sl_lat = 1;
        sl_hold = 1'b0;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(posedge clk); #1; n++;
            if (s_ready_o) ok = 1'b1;
        end
        s_valid_i = 1'b0;
        check("wr5_ack", 32'(ok), 32'd1);
        check("wr5_after_pop", 32'(n_drains - d0 >= 1), 32'd1);
        e.a = 32'h60; e.d = 32'hB000_0004; e.s = 4'hF;
        exp_q.push_back(e);
        ref_mem[word_of(32'h60)] = 32'hB000_0004;
        wait_idle("fill_idle");
        check("fill_drain_count", 32'(n_drains - d0), 32'd5);
        check("fill_queue_empty", 32'(exp_q.size()), 32'd0);

        // Write then read of the same word; downstream answers the read with a distinct value
        sl_lat = 3;
        d0 = n_drains; r0 = n_rd_down;
        req(32'h20, 32'h1111_2222, 4'hF, rd, lat);
        rd_force = 1'b1; rd_force_val = 32'hCAFE_F00D;
        req(32'h20, 32'h0, 4'h0, rd, lat);
`ifdef PSRAM_WBUF_FWD_EN
        check("raw_rdata", rd, 32'h1111_2222);
        check("raw_lat", 32'(lat), 32'd2);
        check("raw_no_rd_down", 32'(n_rd_down - r0), 32'd0);
        rd_force = 1'b0;
`else
        check("raw_rdata", rd, 32'hCAFE_F00D);
        check("raw_wr_first", 32'(n_drains - d0), 32'd1);
        check("raw_rd_down", 32'(n_rd_down - r0), 32'd1);
`endif
        wait_idle("raw_idle");

        // Partial write never forwards; the read goes downstream after the drain
        r0 = n_rd_down;
        req(32'h30, 32'hDEAD_BEEF, 4'b0011, rd, lat);
        req(32'h30, 32'h0, 4'h0, rd, lat);
        check("part_rdata", rd, ref_rd(word_of(32'h30)));
        check("part_rd_down", 32'(n_rd_down - r0), 32'd1);
        sv = rd;
        req(32'h34, 32'h7777_8888, 4'hF, rd, lat);
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", s_rdata_o, sv);
        wait_idle("part_idle");

        // Address bits above AW are dropped downstream
        req(32'hFF80_0004, 32'h0BAD_F00D, 4'hF, rd, lat);
        n = 0;
        while (!m_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        check("amask_m_addr", m_addr_o, 32'h0080_0004);
        wait_idle("amask_idle");

        // Reset with entries queued and a drain in progress
        sl_hold = 1'b1;
        for (int i = 0; i < 3; i++) req(32'h100 + 32'(4 * i), 32'hC0C0_0000 + 32'(i), 4'hF, rd, lat);
        check("rstq_m_valid", 32'(m_valid_o), 32'd1);
        check("rstq_cnt", 32'(fifo_cnt_o), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rstq_m_valid_low", 32'(m_valid_o), 32'd0);
        check("rstq_s_ready_low", 32'(s_ready_o), 32'd0);
        check("rstq_cnt_zero", 32'(fifo_cnt_o), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        sl_hold = 1'b0;
        sl_lat = 2;
        d0 = n_drains;
        req(32'h40, 32'h4040_4040, 4'hF, rd, lat);
        wait_idle("rstq_idle");
        check("rstq_one_drain", 32'(n_drains - d0), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("rstq_still_one", 32'(n_drains - d0), 32'd1);
        check("rstq_no_valid", 32'(m_valid_o), 32'd0);

        // Randomized mixed traffic against the memory model
        sl_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            w = $urandom_range(0, 7);
            a = ($urandom & 32'hFF00_0000) | 32'(w << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            rsel = $urandom_range(0, 5);
            if (rsel < 2)      st = 4'h0;
            else if (rsel < 4) st = 4'hF;
            else               st = 4'($urandom_range(1, 14));
            if (st == 4'h0) begin
                req(a, 32'h0, 4'h0, rd, lat);
                check("rand_rdata", rd, ref_rd(w));
            end else begin
                req(a, d, st, rd, lat);
                check("rand_wr_lat", 32'(lat <= 2 + 4 * DEPTH + 8), 32'd1);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle("rand_idle");
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 8; k++) check("rand_mem", sl_rd(k), ref_rd(k));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
